// File: rtl/fight_pkg.sv
// Shared types and codes for the match controller and its action slots.
// Holds the FSM state enum, player action codes and match-winner codes.
package fight_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROUND_INIT,
        S_COLLECT,
        S_ISSUE,
        S_SETTLE,
        S_CHECK,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [2:0] ACT_IDLE    = 3'b000;
    localparam logic [2:0] ACT_LEFT    = 3'b001;
    localparam logic [2:0] ACT_RIGHT   = 3'b010;
    localparam logic [2:0] ACT_JUMP    = 3'b011;
    localparam logic [2:0] ACT_PUNCH   = 3'b100;
    localparam logic [2:0] ACT_KICK    = 3'b101;
    localparam logic [2:0] ACT_BLOCK   = 3'b110;
    localparam logic [2:0] ACT_SPECIAL = 3'b111;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    function automatic logic [1:0] decode_winner(input logic [1:0] r1, input logic [1:0] r2);
        if (r1 > r2)      return WIN_P1;
        else if (r2 > r1) return WIN_P2;
        else              return WIN_DRAW;
    endfunction

endpackage

// File: rtl/action_slot.sv
// One-entry capture of a player's action for the current turn.
// Priority: clear, then handshake, then default load on timeout.
module action_slot
    import fight_pkg::*;
(
    input  logic       clk,
    input  logic       resetGame,
    input  logic       enable,
    input  logic       clear,
    input  logic       load_default,
    input  logic       valid,
    input  logic [2:0] act,
    output logic       ready,
    output logic       full,
    output logic [2:0] action
);

    // valid/ready: a transfer happens on a rising edge where both are high;
    // valid while ready is low is ignored, and ready never depends on valid.
    assign ready = enable && !full;

    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) begin
            full   <= 1'b0;
            action <= ACT_IDLE;
        end else if (clear) begin
            full   <= 1'b0;
            action <= ACT_IDLE;
        end else if (valid && ready) begin
            full   <= 1'b1;
            action <= act;
        end else if (load_default && !full) begin
            full   <= 1'b1;
            action <= ACT_IDLE;
        end
    end

endmodule

// File: rtl/match_controller.sv
// Best-of-N match sequencer around the fighting core: collects per-turn
// actions, strobes them into the core, scores rounds and resets the core.
module match_controller
    import fight_pkg::*;
#(
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5,
    parameter int TURN_TIMEOUT  = 15,
    parameter int PAUSE_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       resetGame,
    input  logic       start,
    input  logic       valid1,
    input  logic       valid2,
    input  logic [2:0] act1,
    input  logic [2:0] act2,
    output logic       ready1,
    output logic       ready2,
    input  logic       firstWin,
    input  logic       secondWin,
    output logic [2:0] coreAction1,
    output logic [2:0] coreAction2,
    output logic       coreActionEnable,
    output logic       coreReset,
    output logic [1:0] rounds1,
    output logic [1:0] rounds2,
    output logic       matchDone,
    output logic [1:0] matchWinner
);

    state_t     state, next_state;
    logic [7:0] timer;
    logic [2:0] roundsPlayed;
    logic [1:0] rounds1_n, rounds2_n;
    logic [2:0] played_n;
    logic       clr_scores, score_we;
    logic       slot_en, slot_clear, timeout;
    logic       full1, full2;
    logic [2:0] slot_act1, slot_act2;
    logic [2:0] hold1, hold2;

    assign slot_en    = (state == S_COLLECT);
    assign timeout    = slot_en && (timer == 8'(TURN_TIMEOUT - 1));
    assign slot_clear = (next_state == S_COLLECT) && (state != S_COLLECT);

    action_slot u_slot1 (
        .clk(clk), .resetGame(resetGame), .enable(slot_en), .clear(slot_clear),
        .load_default(timeout), .valid(valid1), .act(act1),
        .ready(ready1), .full(full1), .action(slot_act1)
    );

    action_slot u_slot2 (
        .clk(clk), .resetGame(resetGame), .enable(slot_en), .clear(slot_clear),
        .load_default(timeout), .valid(valid2), .act(act2),
        .ready(ready2), .full(full2), .action(slot_act2)
    );

    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) state <= S_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        clr_scores = 1'b0;
        score_we   = 1'b0;
        rounds1_n  = rounds1;
        rounds2_n  = rounds2;
        played_n   = roundsPlayed;
        if (firstWin && !secondWin && rounds1 != 2'(ROUNDS_TO_WIN))
            rounds1_n = rounds1 + 2'd1;
        if (secondWin && !firstWin && rounds2 != 2'(ROUNDS_TO_WIN))
            rounds2_n = rounds2 + 2'd1;
        if (roundsPlayed != 3'(MAX_ROUNDS))
            played_n = roundsPlayed + 3'd1;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_state = S_ROUND_INIT;
                    clr_scores = 1'b1;
                end
            end
            S_ROUND_INIT: next_state = S_COLLECT;
            S_COLLECT: begin
                // A same-edge handshake counts as filled; otherwise the timeout
                // makes the slots take ACT_IDLE on this edge.
                if (((full1 || (valid1 && ready1)) && (full2 || (valid2 && ready2))) || timeout)
                    next_state = S_ISSUE;
            end
            S_ISSUE:  next_state = S_SETTLE;
            S_SETTLE: next_state = S_CHECK;
            S_CHECK: begin
                if (firstWin || secondWin) begin
                    score_we = 1'b1;
                    if (rounds1_n == 2'(ROUNDS_TO_WIN) || rounds2_n == 2'(ROUNDS_TO_WIN) ||
                        played_n == 3'(MAX_ROUNDS))
                        next_state = S_DONE;
                    else
                        next_state = S_PAUSE;
                end else begin
                    next_state = S_COLLECT;
                end
            end
            S_PAUSE: begin
                if (timer == 8'(PAUSE_CYCLES - 1)) next_state = S_ROUND_INIT;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // One timer serves both the turn timeout and the inter-round pause.
    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame)
            timer <= 8'd0;
        else if (next_state != state)
            timer <= 8'd0;
        else if (state == S_COLLECT || state == S_PAUSE)
            timer <= timer + 8'd1;
    end

    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) begin
            rounds1      <= 2'd0;
            rounds2      <= 2'd0;
            roundsPlayed <= 3'd0;
        end else if (clr_scores) begin
            rounds1      <= 2'd0;
            rounds2      <= 2'd0;
            roundsPlayed <= 3'd0;
        end else if (score_we) begin
            rounds1      <= rounds1_n;
            rounds2      <= rounds2_n;
            roundsPlayed <= played_n;
        end
    end

    // The core keeps seeing the last issued actions until the next ISSUE.
    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) begin
            hold1 <= ACT_IDLE;
            hold2 <= ACT_IDLE;
        end else if (state == S_ISSUE) begin
            hold1 <= slot_act1;
            hold2 <= slot_act2;
        end
    end

    always_comb begin
        coreActionEnable = (state == S_ISSUE);
        coreAction1      = (state == S_ISSUE) ? slot_act1 : hold1;
        coreAction2      = (state == S_ISSUE) ? slot_act2 : hold2;
        coreReset        = !(state == S_IDLE || state == S_ROUND_INIT);
        matchDone        = (state == S_DONE);
        matchWinner      = WIN_NONE;
        if (state == S_DONE) matchWinner = decode_winner(rounds1, rounds2);
    end

endmodule
